// File: rtl/nw_traffic_gen.sv
// Per-node Bernoulli packet generator feeding the mesh injection ports through
// show-ahead queues, with global injected/dropped/ejected statistics.
package nw_traffic_gen_pkg;
  localparam int COORD_W   = 4;
  localparam int NUM_MEM   = 4;
  localparam int MEM_CNT_W = 3;
  localparam int PKT_TS_W  = 16;

  typedef struct packed {
    logic [7:0]                        id;
    logic [COORD_W-1:0]                x_source;
    logic [COORD_W-1:0]                y_source;
    logic [COORD_W-1:0]                x_dest;
    logic [COORD_W-1:0]                y_dest;
    logic                              ant;
    logic                              backward;
    logic [NUM_MEM-1:0][COORD_W-1:0]   x_memory;
    logic [NUM_MEM-1:0][COORD_W-1:0]   y_memory;
    logic [MEM_CNT_W-1:0]              num_memories;
    logic                              measure;
    logic [PKT_TS_W-1:0]               timestamp;
  } packet_t;
endpackage

module nw_traffic_gen
  import nw_traffic_gen_pkg::*;
#(
  parameter int          X_NODES     = 4,
  parameter int          Y_NODES     = 4,
  parameter int          QUEUE_DEPTH = 16,
  parameter int          TS_W        = 16,
  parameter logic [31:0] SEED        = 32'h1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                i_enable,
  input  logic [1:0]                          i_mode,
  input  logic [10:0]                         i_rate,
  input  logic [$clog2(X_NODES*Y_NODES)-1:0]  i_hotspot,
  input  logic [X_NODES*Y_NODES-1:0]          i_net_ready,
  output packet_t [X_NODES*Y_NODES-1:0]       o_data,
  output logic [X_NODES*Y_NODES-1:0]          o_data_val,
  input  logic [X_NODES*Y_NODES-1:0]          i_eject_val,
  output logic [31:0]                         o_injected_cnt,
  output logic [31:0]                         o_dropped_cnt,
  output logic [31:0]                         o_ejected_cnt
);
  localparam int          NODES     = X_NODES * Y_NODES;
  localparam int          XW        = $clog2(X_NODES);
  localparam int          YW        = $clog2(Y_NODES);
  localparam int          AW        = $clog2(QUEUE_DEPTH);
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;  // x^32+x^22+x^2+x+1

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [NODES-1:0] pop_vec, drop_vec;
  logic [31:0]      inj_q, inj_d, drop_q, drop_d, ej_q, ej_d;

  function automatic logic [31:0] sat_add(input logic [31:0] cnt, input logic [NODES-1:0] ev);
    logic [32:0] sum;
    sum = {1'b0, cnt};
    for (int i = 0; i < NODES; i++) sum = sum + 33'(ev[i]);
    return sum[32] ? '1 : sum[31:0];
  endfunction

  for (genvar gi = 0; gi < NODES; gi++) begin : g_node
    localparam int          XS        = gi % X_NODES;
    localparam int          YS        = gi / X_NODES;
    localparam logic [31:0] SEED_RAW  = SEED ^ 32'(gi + 1);
    localparam logic [31:0] LFSR_INIT = (SEED_RAW == 32'd0) ? 32'd1 : SEED_RAW;

    logic [31:0]        lfsr_q, lfsr_d;
    logic [7:0]         id_q, id_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    packet_t            fifo_mem [QUEUE_DEPTH];
    packet_t            pkt;
    logic               gen, pop, push;
    logic [COORD_W-1:0] x_dest, y_dest;

    always_comb begin
      x_dest = '0;
      y_dest = '0;
      case (i_mode)
        2'd0: begin
          x_dest = COORD_W'(lfsr_q[16 +: XW]);
          y_dest = COORD_W'(lfsr_q[24 +: YW]);
        end
        2'd1: begin
          x_dest = COORD_W'(YS % X_NODES);
          y_dest = COORD_W'(XS % Y_NODES);
        end
        2'd2: begin
          x_dest = COORD_W'(X_NODES - 1 - XS);
          y_dest = COORD_W'(Y_NODES - 1 - YS);
        end
        default: begin
          x_dest = COORD_W'(i_hotspot[XW-1:0]);
          y_dest = COORD_W'(i_hotspot[XW +: YW]);
        end
      endcase

      pkt           = '0;
      pkt.id        = id_q;
      pkt.x_source  = COORD_W'(XS);
      pkt.y_source  = COORD_W'(YS);
      pkt.x_dest    = x_dest;
      pkt.y_dest    = y_dest;
      pkt.timestamp = PKT_TS_W'(ts_q);

      // Generation decision uses the LFSR value before this cycle's advance.
      gen  = i_enable && ({1'b0, lfsr_q[9:0]} < i_rate);
      pop  = (count_q != '0) && i_net_ready[gi];
      push = gen && ((count_q != (AW+1)'(QUEUE_DEPTH)) || pop);

      lfsr_d   = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'd0);
      id_d     = id_q + 8'(gen);
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        lfsr_q   <= LFSR_INIT;
        id_q     <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        lfsr_q   <= lfsr_d;
        id_q     <= id_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
      end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= pkt;
    end

    assign pop_vec[gi]    = pop;
    assign drop_vec[gi]   = gen && !push;
    assign o_data_val[gi] = (count_q != '0);
    assign o_data[gi]     = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;
  end

  always_comb begin
    ts_d   = ts_q + 1'b1;
    inj_d  = sat_add(inj_q, pop_vec);
    drop_d = sat_add(drop_q, drop_vec);
    ej_d   = sat_add(ej_q, i_eject_val);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ts_q   <= '0;
      inj_q  <= '0;
      drop_q <= '0;
      ej_q   <= '0;
    end else begin
      ts_q   <= ts_d;
      inj_q  <= inj_d;
      drop_q <= drop_d;
      ej_q   <= ej_d;
    end
  end

  assign o_injected_cnt = inj_q;
  assign o_dropped_cnt  = drop_q;
  assign o_ejected_cnt  = ej_q;
endmodule

// File: tb/tb_nw_traffic_gen.sv
// Directed bench for nw_traffic_gen: a cycle model pushes expected packets into
// per-node queues and every DUT head/valid/counter is compared each cycle.
module tb_nw_traffic_gen;
  import nw_traffic_gen_pkg::*;

  localparam int XN = 4;
  localparam int YN = 4;
  localparam int N  = XN * YN;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_enable = 1'b0;
  logic [1:0]    i_mode = 2'd0;
  logic [10:0]   i_rate = 11'd0;
  logic [3:0]    i_hotspot = 4'd0;
  logic [N-1:0]  i_net_ready = '0;
  logic [N-1:0]  i_eject_val = '0;
  packet_t [N-1:0] o_data;
  logic [N-1:0]  o_data_val;
  logic [31:0]   o_injected_cnt, o_dropped_cnt, o_ejected_cnt;

  always #5 clk = ~clk;

  nw_traffic_gen #(
    .X_NODES(XN), .Y_NODES(YN), .QUEUE_DEPTH(D), .TS_W(16), .SEED(32'h1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .i_enable(i_enable), .i_mode(i_mode),
    .i_rate(i_rate), .i_hotspot(i_hotspot), .i_net_ready(i_net_ready),
    .o_data(o_data), .o_data_val(o_data_val), .i_eject_val(i_eject_val),
    .o_injected_cnt(o_injected_cnt), .o_dropped_cnt(o_dropped_cnt),
    .o_ejected_cnt(o_ejected_cnt)
  );

  int checks = 0;
  int failures = 0;

  packet_t     sb_q [N][$];
  logic [31:0] m_lfsr [N];
  logic [7:0]  m_id [N];
  logic [15:0] m_ts;
  logic [31:0] m_inj, m_drop, m_ej;
  bit          m_valid = 1'b0;

  bit          collect = 1'b0;
  int          pop_seen [N];
  int          last_id [N];
  bit [15:0]   x_hit, y_hit;
  bit          wrap_seen;

  task automatic check(input string tag, input int node, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s node=%0d observed=%0h expected=%0h", tag, node, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat(input logic [31:0] c, input int add);
    longint t;
    t = longint'(c) + longint'(add);
    return (t > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : t[31:0];
  endfunction

  task automatic model_reset();
    logic [31:0] s;
    for (int n = 0; n < N; n++) begin
      sb_q[n].delete();
      s = 32'h1 ^ 32'(n + 1);
      m_lfsr[n] = (s == 32'd0) ? 32'd1 : s;
      m_id[n] = 8'd0;
    end
    m_ts = 16'd0;
    m_inj = 32'd0;
    m_drop = 32'd0;
    m_ej = 32'd0;
    m_valid = 1'b1;
  endtask

  // One clock: compare at negedge, predict this cycle's events, commit at posedge.
  task automatic cycle();
    bit      gen [N];
    bit      pop [N];
    bit      push [N];
    packet_t pkt [N];
    int      npop, ndrop, xs, ys;
    logic [127:0] exp_head;
    npop = 0;
    ndrop = 0;
    @(negedge clk);
    if (m_valid) begin
      for (int n = 0; n < N; n++) begin
        exp_head = (sb_q[n].size() != 0) ? 128'(sb_q[n][0]) : 128'(0);
        check("valid", n, 128'(o_data_val[n]), 128'(sb_q[n].size() != 0));
        check("head", n, 128'(o_data[n]), exp_head);
        if (collect && o_data_val[n] && i_net_ready[n]) begin
          pop_seen[n]++;
          x_hit[o_data[n].x_dest] = 1'b1;
          y_hit[o_data[n].y_dest] = 1'b1;
          if (last_id[n] == 255 && o_data[n].id == 8'd0) wrap_seen = 1'b1;
          last_id[n] = int'(o_data[n].id);
        end
      end
      check("injected_cnt", -1, 128'(o_injected_cnt), 128'(m_inj));
      check("dropped_cnt", -1, 128'(o_dropped_cnt), 128'(m_drop));
      check("ejected_cnt", -1, 128'(o_ejected_cnt), 128'(m_ej));
    end
    for (int n = 0; n < N; n++) begin
      xs = n % XN;
      ys = n / XN;
      gen[n] = i_enable && (int'(m_lfsr[n] & 32'h3FF) < int'(i_rate));
      pkt[n] = '0;
      pkt[n].id = m_id[n];
      pkt[n].x_source = 4'(xs);
      pkt[n].y_source = 4'(ys);
      pkt[n].timestamp = m_ts;
      case (i_mode)
        2'd0: begin pkt[n].x_dest = 4'((m_lfsr[n] >> 16) & 3); pkt[n].y_dest = 4'((m_lfsr[n] >> 24) & 3); end
        2'd1: begin pkt[n].x_dest = 4'(ys % XN); pkt[n].y_dest = 4'(xs % YN); end
        2'd2: begin pkt[n].x_dest = 4'(XN - 1 - xs); pkt[n].y_dest = 4'(YN - 1 - ys); end
        default: begin pkt[n].x_dest = 4'(int'(i_hotspot) % XN); pkt[n].y_dest = 4'(int'(i_hotspot) / XN); end
      endcase
      pop[n] = (sb_q[n].size() != 0) && i_net_ready[n];
      push[n] = gen[n] && ((sb_q[n].size() < D) || pop[n]);
      if (pop[n]) npop++;
      if (gen[n] && !push[n]) ndrop++;
    end
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else if (m_valid) begin
      for (int n = 0; n < N; n++) begin
        if (pop[n]) void'(sb_q[n].pop_front());
        if (push[n]) sb_q[n].push_back(pkt[n]);
        if (gen[n]) m_id[n] = m_id[n] + 8'd1;
        m_lfsr[n] = (m_lfsr[n] >> 1) ^ (m_lfsr[n][0] ? 32'h8020_0003 : 32'd0);
      end
      m_ts = m_ts + 16'd1;
      m_inj = sat(m_inj, npop);
      m_drop = sat(m_drop, ndrop);
      m_ej = sat(m_ej, $countones(i_eject_val));
    end
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [31:0] d0;
    int frac;

    // Power-on reset.
    reset_n = 1'b0;
    repeat (3) cycle();
    check("rst_valid", -1, 128'(o_data_val), 128'(0));
    check("rst_inj", -1, 128'(o_injected_cnt), 128'(0));
    reset_n = 1'b1;

    // Rate 0 then enable 0: nothing may appear.
    i_enable = 1'b1; i_rate = 11'd0; i_net_ready = '1;
    repeat (100) cycle();
    i_enable = 1'b0; i_rate = 11'd1024;
    repeat (100) cycle();
    check("idle_valid", -1, 128'(o_data_val), 128'(0));
    check("idle_inj", -1, 128'(o_injected_cnt), 128'(0));
    check("idle_drop", -1, 128'(o_dropped_cnt), 128'(0));

    // Mid-traffic reset discards queued packets and clears counters.
    i_enable = 1'b1; i_net_ready = '0; i_mode = 2'd3;
    repeat (20) cycle();
    reset_n = 1'b0;
    cycle();
    check("midrst_valid", -1, 128'(o_data_val), 128'(0));
    check("midrst_drop", -1, 128'(o_dropped_cnt), 128'(0));
    for (int n = 0; n < N; n += 5) check("midrst_data", n, 128'(o_data[n]), 128'(0));
    reset_n = 1'b1;

    // Hotspot at node 0, full rate, all ready.
    do_reset();
    i_enable = 1'b1; i_rate = 11'd1024; i_mode = 2'd3; i_hotspot = 4'd0; i_net_ready = '1;
    for (int k = 1; k <= 100; k++) begin
      cycle();
      if (k < 100) check("hot_all_valid", k, 128'(o_data_val), 128'(16'hFFFF));
    end
    check("hot_injected", -1, 128'(o_injected_cnt), 128'(99 * N));
    check("hot_dropped", -1, 128'(o_dropped_cnt), 128'(0));
    check("hot_dest_x", 7, 128'(o_data[7].x_dest), 128'(0));

    // Backpressure on node 0: fill, drop one per cycle, then drain while full.
    do_reset();
    i_net_ready = 16'hFFFE;
    repeat (10) cycle();
    check("bp_dropped", 0, 128'(o_dropped_cnt), 128'(6));
    check("bp_head_id", 0, 128'(o_data[0].id), 128'(0));
    d0 = o_dropped_cnt;
    cycle();
    check("bp_drop_step", 0, 128'(o_dropped_cnt - d0), 128'(1));
    i_net_ready = '1;
    repeat (4) cycle();
    check("full_pushpop_nodrop", 0, 128'(o_dropped_cnt), 128'(7));
    check("full_valid", 0, 128'(o_data_val[0]), 128'(1));
    repeat (4) cycle();

    // Transpose and bit-complement destinations.
    do_reset();
    i_mode = 2'd1; i_net_ready = '0;
    cycle();
    check("tr_n9", 9, 128'({o_data[9].x_dest, o_data[9].y_dest}), 128'(8'h21));
    check("tr_n12", 12, 128'({o_data[12].x_dest, o_data[12].y_dest}), 128'(8'h30));
    do_reset();
    i_mode = 2'd2;
    cycle();
    check("bc_n9", 9, 128'({o_data[9].x_dest, o_data[9].y_dest}), 128'(8'h21));
    check("bc_n12", 12, 128'({o_data[12].x_dest, o_data[12].y_dest}), 128'(8'h30));

    // Uniform at half rate over a long window.
    do_reset();
    i_mode = 2'd0; i_rate = 11'd512; i_net_ready = '1;
    for (int n = 0; n < N; n++) begin pop_seen[n] = 0; last_id[n] = -1; end
    x_hit = '0; y_hit = '0; wrap_seen = 1'b0; collect = 1'b1;
    repeat (10000) cycle();
    collect = 1'b0;
    for (int n = 0; n < N; n++) begin
      frac = pop_seen[n] / 10;
      check("rate_frac_ok", n, 128'((frac >= 470) && (frac <= 530)), 128'(1));
    end
    check("x_dest_cover", -1, 128'(x_hit), 128'(16'h000F));
    check("y_dest_cover", -1, 128'(y_hit), 128'(16'h000F));
    check("id_wrap", -1, 128'(wrap_seen), 128'(1));

    // Ejection counting.
    do_reset();
    i_enable = 1'b0; i_eject_val = 16'h000B;
    repeat (10) cycle();
    check("ejected_30", -1, 128'(o_ejected_cnt), 128'(30));
    i_eject_val = '0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
